// File: rtl/uart_rx_buffer.sv
// UART receiver (8N1) feeding a first-word-fall-through byte FIFO with sticky error flags.
// Define UART_RX_PARITY_EN for an even-parity bit after bit 7 (8E1); otherwise parity_error is tied to 0.
module uart_rx_buffer #(
  parameter int CLOCK_FREQ  = 50000000,
  parameter int BAUD_RATE   = 115200,
  parameter int BUFFER_SIZE = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             rx,
  input  logic                             rd_en,
  input  logic                             clr_err,
  output logic [7:0]                       rd_data,
  output logic                             empty,
  output logic                             full,
  output logic [$clog2(BUFFER_SIZE+1)-1:0] count,
  output logic                             frame_error,
  output logic                             overrun,
  output logic                             parity_error
);

  localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int PTR_W        = $clog2(BUFFER_SIZE);
  localparam int CW           = $clog2(BUFFER_SIZE + 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  logic             rx_meta_q, rx_sync_q;
  logic [1:0]       settle_q, settle_d;
  logic             line_high_q, line_high_d;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             frame_error_q, frame_error_d, overrun_q, overrun_d;
  logic             push_req, frame_set, fall, pop, wr_en, overrun_set;
  logic [7:0]       mem_q [BUFFER_SIZE];
`ifdef UART_RX_PARITY_EN
  logic             parity_bad_q, parity_bad_d, parity_error_q, parity_error_d, parity_set;
`endif

  // The synchronizer resets to 1, so its output is not trusted until two real samples have arrived.
  assign fall = settle_q[1] & line_high_q & ~rx_sync_q;

  always_comb begin
    settle_d    = {settle_q[0], 1'b1};
    line_high_d = settle_q[1] & rx_sync_q;
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_W'(1);
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    push_req    = 1'b0;
    frame_set   = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_bad_d = parity_bad_q;
    parity_set   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (fall) state_d = START;
      end
      START: begin
`ifdef UART_RX_PARITY_EN
        parity_bad_d = 1'b0;
`endif
        if (cnt_q == HALF_LAST) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rx_sync_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d     = '0;
          shift_d   = {rx_sync_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d        = '0;
          parity_bad_d = (^shift_q) != rx_sync_q;
          parity_set   = parity_bad_d;
          state_d      = STOP;
        end
      end
`endif
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (rx_sync_q) begin
`ifdef UART_RX_PARITY_EN
            push_req = ~parity_bad_q;
`else
            push_req = 1'b1;
`endif
          end else begin
            frame_set = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A push on a full FIFO only lands if a pop frees the head slot in the same cycle.
  always_comb begin
    pop         = rd_en & ~empty;
    wr_en       = push_req & (~full | pop);
    overrun_set = push_req & full & ~pop;
    wr_ptr_d    = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d    = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d     = count_q;
    if (wr_en && !pop) count_d = count_q + CW'(1);
    else if (!wr_en && pop) count_d = count_q - CW'(1);
    frame_error_d = frame_set | (frame_error_q & ~clr_err);
    overrun_d     = overrun_set | (overrun_q & ~clr_err);
`ifdef UART_RX_PARITY_EN
    parity_error_d = parity_set | (parity_error_q & ~clr_err);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q     <= 1'b1;
      rx_sync_q     <= 1'b1;
      settle_q      <= '0;
      line_high_q   <= 1'b0;
      state_q       <= IDLE;
      cnt_q         <= '0;
      bit_idx_q     <= '0;
      shift_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      frame_error_q <= 1'b0;
      overrun_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bad_q   <= 1'b0;
      parity_error_q <= 1'b0;
`endif
    end else begin
      rx_meta_q     <= rx;
      rx_sync_q     <= rx_meta_q;
      settle_q      <= settle_d;
      line_high_q   <= line_high_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_idx_q     <= bit_idx_d;
      shift_q       <= shift_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      frame_error_q <= frame_error_d;
      overrun_q     <= overrun_d;
`ifdef UART_RX_PARITY_EN
      parity_bad_q   <= parity_bad_d;
      parity_error_q <= parity_error_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= shift_q;
  end

  assign rd_data     = mem_q[rd_ptr_q];
  assign empty       = (count_q == '0);
  assign full        = (count_q == CW'(BUFFER_SIZE));
  assign count       = count_q;
  assign frame_error = frame_error_q;
  assign overrun     = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign parity_error = parity_error_q;
`else
  assign parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Self-checking bench for uart_rx_buffer: directed table, multi-cycle corner cases and random frames
// checked against a queue-based model of the receive FIFO and its sticky flags.
module tb_uart_rx_buffer;

  localparam int CPB = 10;
  localparam int BUF = 4;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic       clk = 1'b0;
  logic       rst, rx, rd_en, clr_err;
  logic [7:0] rd_data;
  logic       empty, full, frame_error, overrun, parity_error;
  logic [2:0] count;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         frame_start = 0;
  int         fall_cyc = -1;
  int         latency;
  logic       empty_prev = 1'b1;
  logic [7:0] model_q[$];
  logic       m_fe = 1'b0, m_ov = 1'b0, m_pe = 1'b0;
`ifdef UART_RX_PARITY_EN
  logic       par_flip = 1'b0;
`endif

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_count;
    logic       exp_full;
    logic       exp_ov;
  } vec_t;
  vec_t vecs[5];

  uart_rx_buffer #(
    .CLOCK_FREQ(1000000),
    .BAUD_RATE(100000),
    .BUFFER_SIZE(BUF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx(rx),
    .rd_en(rd_en),
    .clr_err(clr_err),
    .rd_data(rd_data),
    .empty(empty),
    .full(full),
    .count(count),
    .frame_error(frame_error),
    .overrun(overrun),
    .parity_error(parity_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (empty_prev && !empty) fall_cyc = cyc;
    empty_prev = empty;
  end

  initial begin
    #(100000 * 10);
    $display("[TB] FAIL timeout actual=running required=finished");
    $fatal(1, "[TB] timeout");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic checkModel(input string tag);
    checkOutput({tag, ".empty"}, int'(empty), (model_q.size() == 0) ? 1 : 0);
    checkOutput({tag, ".count"}, int'(count), model_q.size());
    checkOutput({tag, ".full"}, int'(full), (model_q.size() == BUF) ? 1 : 0);
    checkOutput({tag, ".frame_error"}, int'(frame_error), int'(m_fe));
    checkOutput({tag, ".overrun"}, int'(overrun), int'(m_ov));
    checkOutput({tag, ".parity_error"}, int'(parity_error), int'(m_pe));
    if (model_q.size() != 0) checkOutput({tag, ".rd_data"}, int'(rd_data), int'(model_q[0]));
  endtask

  // Serial frame: start, 8 data bits LSB first, optional parity, stop, then one idle bit time.
  task automatic applyStimulus(input logic [7:0] d, input logic stop_bit);
    rx = 1'b0;
    frame_start = cyc;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      tick(CPB);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^d) ^ par_flip;
    tick(CPB);
`endif
    rx = stop_bit;
    tick(CPB);
    rx = 1'b1;
    tick(CPB);
  endtask

  task automatic modelFrame(input logic [7:0] d, input logic stop_bit);
    logic par_ok;
`ifdef UART_RX_PARITY_EN
    par_ok = ~par_flip;
`else
    par_ok = 1'b1;
`endif
    if (!par_ok) m_pe = 1'b1;
    if (!stop_bit) m_fe = 1'b1;
    else if (par_ok) begin
      if (model_q.size() == BUF) m_ov = 1'b1;
      else model_q.push_back(d);
    end
  endtask

  task automatic sendFrame(input logic [7:0] d, input logic stop_bit);
    applyStimulus(d, stop_bit);
    modelFrame(d, stop_bit);
  endtask

  task automatic popOne(input string tag);
    if (model_q.size() != 0) checkOutput({tag, ".pop_data"}, int'(rd_data), int'(model_q[0]));
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
    if (model_q.size() != 0) void'(model_q.pop_front());
  endtask

  task automatic clearErrors();
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    m_fe = 1'b0;
    m_ov = 1'b0;
    m_pe = 1'b0;
  endtask

  initial begin
    vecs[0] = '{8'h00, 1'b1, 1, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 1'b1, 2, 1'b0, 1'b0};
    vecs[2] = '{8'h3C, 1'b1, 3, 1'b0, 1'b0};
    vecs[3] = '{8'h81, 1'b1, 4, 1'b1, 1'b0};
    vecs[4] = '{8'h55, 1'b1, 4, 1'b1, 1'b1};

    rst = 1'b1; rx = 1'b1; rd_en = 1'b0; clr_err = 1'b0;
    tick(5);
    checkModel("reset");
    rst = 1'b0;
    tick(5);

    // Single byte; the push must land inside the stop bit and be the only change.
    fall_cyc = -1;
    sendFrame(8'hA5, 1'b1);
    latency = fall_cyc - frame_start;
    checkOutput("a5.push_in_stop_bit",
                (fall_cyc >= 0 && latency > (NBITS - 1) * CPB && latency <= NBITS * CPB) ? 1 : 0, 1);
    if (fall_cyc < 0 || latency <= 1) latency = NBITS * CPB - 2;
    checkOutput("a5.rd_data", int'(rd_data), 8'hA5);
    checkOutput("a5.count", int'(count), 1);
    checkModel("a5");
    popOne("a5");

    rd_en = 1'b1;
    tick(3);
    rd_en = 1'b0;
    checkModel("pop_empty");

    // Fill past capacity with no reads.
    for (int i = 0; i < 5; i++) begin
      sendFrame(vecs[i].data, vecs[i].stop);
      checkOutput($sformatf("fill%0d.count", i), int'(count), vecs[i].exp_count);
      checkOutput($sformatf("fill%0d.full", i), int'(full), int'(vecs[i].exp_full));
      checkOutput($sformatf("fill%0d.overrun", i), int'(overrun), int'(vecs[i].exp_ov));
      checkModel($sformatf("fill%0d", i));
    end
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("drain%0d.data", i), int'(rd_data), int'(vecs[i].data));
      popOne($sformatf("drain%0d", i));
    end
    checkModel("drained");
    clearErrors();
    checkModel("clr_after_overrun");

    // Short low glitch must be rejected, then a frame with a low stop bit.
    rx = 1'b0;
    tick(3);
    rx = 1'b1;
    tick(30);
    checkModel("glitch");
    sendFrame(8'h12, 1'b0);
    checkOutput("badstop.frame_error", int'(frame_error), 1);
    checkOutput("badstop.count", int'(count), 0);
    checkModel("badstop");
    clearErrors();
    checkModel("clr_after_frame_error");
    sendFrame(8'h5A, 1'b1);
    checkModel("after_glitch_ok");
    popOne("after_glitch_ok");

    // Full FIFO with a pop exactly on the push cycle.
    sendFrame(8'h11, 1'b1);
    sendFrame(8'h22, 1'b1);
    sendFrame(8'h33, 1'b1);
    sendFrame(8'h44, 1'b1);
    checkModel("refill");
    fork
      applyStimulus(8'h99, 1'b1);
      begin
        tick(latency - 1);
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
      end
    join
    void'(model_q.pop_front());
    modelFrame(8'h99, 1'b1);
    checkOutput("simul.count", int'(count), 4);
    checkOutput("simul.overrun", int'(overrun), 0);
    checkModel("simul");
    for (int i = 0; i < 4; i++) popOne($sformatf("simul_drain%0d", i));
    checkModel("simul_drained");

    // Reset in the middle of byte 0x77, line left low across the release.
    rx = 1'b0;
    tick(CPB);
    rx = 1'b1;
    tick(3 * CPB);
    rx = 1'b0;
    tick(4);
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    model_q.delete();
    m_fe = 1'b0; m_ov = 1'b0; m_pe = 1'b0;
    tick(25);
    rx = 1'b1;
    tick(30);
    checkModel("post_reset_idle");
    sendFrame(8'h42, 1'b1);
    checkOutput("post_reset.rd_data", int'(rd_data), 8'h42);
    checkOutput("post_reset.count", int'(count), 1);
    popOne("post_reset");
    checkModel("post_reset_empty");

`ifdef UART_RX_PARITY_EN
    par_flip = 1'b1;
    sendFrame(8'h03, 1'b1);
    par_flip = 1'b0;
    checkOutput("par_bad.parity_error", int'(parity_error), 1);
    checkOutput("par_bad.count", int'(count), 0);
    checkModel("par_bad");
    sendFrame(8'h03, 1'b1);
    checkOutput("par_ok.rd_data", int'(rd_data), 8'h03);
    checkModel("par_ok");
    clearErrors();
    popOne("par_ok");
`endif

    // Random traffic against the queue model.
    for (int n = 0; n < 30; n++) begin
      logic [7:0] d;
      logic       stop_bit;
      d = 8'($urandom);
      stop_bit = ($urandom_range(0, 7) != 0);
`ifdef UART_RX_PARITY_EN
      par_flip = ($urandom_range(0, 7) == 0);
`endif
      sendFrame(d, stop_bit);
      checkModel($sformatf("rand%0d", n));
      for (int p = $urandom_range(0, 2); p > 0; p--) popOne($sformatf("rand%0d", n));
      if ($urandom_range(0, 4) == 0) clearErrors();
    end
`ifdef UART_RX_PARITY_EN
    par_flip = 1'b0;
`endif
    checkModel("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
